// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving N agents onto one shared tri-state net, with a forced all-'z turnaround between owners.
// Optional feature: define BUS_KEEPER_EN to add a weak keeper that holds the last granted data on the net.
module tristate_bus_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   grant,
  output wire  [W-1:0]   bus,
  output logic [W-1:0]   rdata,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, TURN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic [TW-1:0]   turn_cnt, turn_nxt;
  logic [N-1:0]    grant_nxt;
  logic [N-1:0]    owner_mask;
  logic            others;
  logic            preempt;

  // First requester at or after ptr, wrapping mod N; the lowest offset wins.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (r[idx]) begin
        pick = PW'(idx);
      end
    end
    return pick;
  endfunction

  // Next-state, pointer, counter and grant computation.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    burst_nxt  = burst_cnt;
    turn_nxt   = turn_cnt;
    owner_mask = {{(N-1){1'b0}}, 1'b1} << owner;
    others     = |(req & ~owner_mask);
    // Using >= keeps an owner that ran past the limit alone from starving a late requester.
    preempt    = (MAX_BURST != 0) && others && (32'(burst_cnt) >= MAX_BURST - 1);
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          owner_nxt = rr_pick(req, rr_ptr);
          burst_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        if (!req[owner] || preempt) begin
          state_nxt  = TURN;
          rr_ptr_nxt = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
          burst_nxt  = '0;
          turn_nxt   = '0;
        end else if (32'(burst_cnt) < MAX_BURST) begin
          burst_nxt = burst_cnt + BW'(1);
        end else begin
          burst_nxt = burst_cnt;
        end
      end
      TURN: begin
        if (32'(turn_cnt) >= TURN_CYC - 1) begin
          turn_nxt = '0;
          if (|req) begin
            state_nxt = OWN;
            owner_nxt = rr_pick(req, rr_ptr);
            burst_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          turn_nxt = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt == OWN) begin
      grant_nxt = {{(N-1){1'b0}}, 1'b1} << owner_nxt;
    end else begin
      grant_nxt = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      turn_cnt  <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_nxt;
      turn_cnt  <= turn_nxt;
      grant     <= grant_nxt;
      busy      <= (state_nxt != IDLE);
      rdata     <= bus;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus = grant[i] ? wdata[i*W +: W] : {W{1'bz}};
  end

`ifdef BUS_KEEPER_EN
  logic [W-1:0] keep;

  // Remember the data the current owner is putting on the net.
  always_ff @(posedge clk) begin
    if (rst) begin
      keep <= '0;
    end else if (state == OWN) begin
      keep <= wdata[int'(owner)*W +: W];
    end else begin
      keep <= keep;
    end
  end

  assign (pull0, pull1) bus = keep;
`else
`endif

endmodule
